// File: rtl/hls_loop_perf_monitor.sv
// Cosim performance probe for one HLS block and its pipelined loop: counts runs,
// latencies, iterations, in-flight depth and initiation intervals from handshake traffic.
module hls_loop_perf_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_runs,
    output logic [CNT_W-1:0]   mod_last_lat,
    output logic [CNT_W-1:0]   loop_runs,
    output logic [CNT_W-1:0]   loop_last_trip,
    output logic [CNT_W-1:0]   loop_last_lat,
    output logic [CNT_W-1:0]   iter_starts,
    output logic [CNT_W-1:0]   iter_ends,
    output logic [CNT_W-1:0]   in_flight,
    output logic [CNT_W-1:0]   ii_min,
    output logic [CNT_W-1:0]   ii_max,
    output logic               frozen
);

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_HOLD} mod_state_t;
    typedef enum logic       {L_IDLE, L_ACTIVE}      loop_state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ALL_ONES) ? v : v + ONE;
    endfunction

    mod_state_t        mod_state;
    loop_state_t       loop_state;
    logic [CNT_W-1:0]  cyc;
    logic [CNT_W-1:0]  start_cyc;
    logic [CNT_W-1:0]  lstart_cyc;
    logic [CNT_W-1:0]  last_istart_cyc;
    logic [CNT_W-1:0]  trip;
    logic              have_last;

    logic              istart, iend, quit;
    logic              mod_start_now, mod_complete, loop_exit;
    logic [CNT_W-1:0]  mod_base, trip_now, ii_d;
    logic              unused_inputs;

    assign unused_inputs = ap_ready ^ loop_ready;

    assign istart = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable;
    assign iend   = (cur_state == iter_end_state)   && !iter_end_block   && iter_end_enable;
    assign quit   = (cur_state == quit_state) && !quit_block && quit_enable && loop_done
                    && (quit_at_end || !iend);

    // A start accepted in IDLE may complete in the same cycle, so latency is measured from cyc itself.
    assign mod_start_now = (mod_state == M_IDLE) && ap_start;
    assign mod_complete  = (((mod_state == M_RUN) || mod_start_now) && ap_done && ap_continue)
                           || ((mod_state == M_HOLD) && ap_continue);
    assign mod_base      = mod_start_now ? cyc : start_cyc;

    assign loop_exit = (loop_state == L_ACTIVE) && ((loop_done && loop_continue) || quit);
    assign trip_now  = istart ? sat_inc(trip) : trip;
    assign ii_d      = cyc - last_istart_cyc;

    assign mod_busy = (mod_state != M_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            mod_state       <= M_IDLE;
            loop_state      <= L_IDLE;
            cyc             <= '0;
            start_cyc       <= '0;
            lstart_cyc      <= '0;
            last_istart_cyc <= '0;
            trip            <= '0;
            have_last       <= 1'b0;
            mod_runs        <= '0;
            mod_last_lat    <= '0;
            loop_runs       <= '0;
            loop_last_trip  <= '0;
            loop_last_lat   <= '0;
            iter_starts     <= '0;
            iter_ends       <= '0;
            in_flight       <= '0;
            ii_min          <= ALL_ONES;
            ii_max          <= '0;
            frozen          <= 1'b0;
        end else if (!frozen) begin
            // NOTE: the cycle finish is first seen already counts as frozen, so nothing else updates.
            if (finish) begin
                frozen <= 1'b1;
            end else begin
                cyc <= sat_inc(cyc);

                unique case (mod_state)
                    M_IDLE: if (ap_start) begin
                        start_cyc <= cyc;
                        if (!ap_done)         mod_state <= M_RUN;
                        else if (!ap_continue) mod_state <= M_HOLD;
                    end
                    M_RUN:  if (ap_done) mod_state <= ap_continue ? M_IDLE : M_HOLD;
                    M_HOLD: if (ap_continue) mod_state <= M_IDLE;
                    default: mod_state <= M_IDLE;
                endcase
                if (mod_complete) begin
                    mod_runs     <= sat_inc(mod_runs);
                    mod_last_lat <= sat_inc(cyc - mod_base);
                end

                if (istart) iter_starts <= sat_inc(iter_starts);
                if (iend)   iter_ends   <= sat_inc(iter_ends);
                if (istart && !iend)                      in_flight <= sat_inc(in_flight);
                else if (iend && !istart && in_flight != '0) in_flight <= in_flight - ONE;

                if (istart) begin
                    last_istart_cyc <= cyc;
                    have_last       <= 1'b1;
                    if (have_last) begin
                        if (ii_d < ii_min) ii_min <= ii_d;
                        if (ii_d > ii_max) ii_max <= ii_d;
                    end
                end

                // Placed after the II update so a new invocation always restarts interval tracking.
                unique case (loop_state)
                    L_IDLE: if (loop_start) begin
                        loop_state <= L_ACTIVE;
                        lstart_cyc <= cyc;
                        trip       <= '0;
                        have_last  <= 1'b0;
                    end
                    L_ACTIVE: begin
                        trip <= trip_now;
                        if (loop_exit) begin
                            loop_state     <= L_IDLE;
                            loop_runs      <= sat_inc(loop_runs);
                            loop_last_trip <= trip_now;
                            loop_last_lat  <= sat_inc(cyc - lstart_cyc);
                        end
                    end
                    default: loop_state <= L_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hls_loop_perf_monitor.sv
// Directed bench for hls_loop_perf_monitor: handshake latencies, loop trip counts,
// II extremes, pipeline occupancy, quit handling and finish freezing.
module tb_hls_loop_perf_monitor;

    logic        clock = 1'b0;
    logic        reset, finish;
    logic        ap_start, ap_ready, ap_done, ap_continue;
    logic [0:0]  cur_state, iter_start_state, iter_end_state, quit_state;
    logic        iter_start_block, iter_end_block, quit_block;
    logic        iter_start_enable, iter_end_enable, quit_enable;
    logic        loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
    logic        mod_busy, frozen;
    logic [31:0] mod_runs, mod_last_lat, loop_runs, loop_last_trip, loop_last_lat;
    logic [31:0] iter_starts, iter_ends, in_flight, ii_min, ii_max;

    int vectors    = 0;
    int miscompares = 0;

    hls_loop_perf_monitor #(.STATE_W(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .mod_busy(mod_busy), .mod_runs(mod_runs), .mod_last_lat(mod_last_lat),
        .loop_runs(loop_runs), .loop_last_trip(loop_last_trip), .loop_last_lat(loop_last_lat),
        .iter_starts(iter_starts), .iter_ends(iter_ends), .in_flight(in_flight),
        .ii_min(ii_min), .ii_max(ii_max), .frozen(frozen)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        cur_state = 0; iter_start_state = 0; iter_end_state = 1; quit_state = 1;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        repeat (3) step();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ap_start = 1; loop_start = 1; iter_start_enable = 1; iter_end_enable = 1; finish = 1;
        reset = 1;
        repeat (3) step();
        vectors++; if (mod_busy !== 1'b0) begin miscompares++; $display("FAIL reset_mod_busy got %0d want 0", mod_busy); end
        vectors++; if (frozen !== 1'b0) begin miscompares++; $display("FAIL reset_frozen got %0d want 0", frozen); end
        vectors++; if (ii_min !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_ii_min got %h want ffffffff", ii_min); end
        vectors++; if ({mod_runs, mod_last_lat, loop_runs, loop_last_trip, loop_last_lat} !== '0)
            begin miscompares++; $display("FAIL reset_run_counters got %h want 0", {mod_runs, mod_last_lat, loop_runs, loop_last_trip, loop_last_lat}); end
        vectors++; if ({iter_starts, iter_ends, in_flight, ii_max, dut.cyc} !== '0)
            begin miscompares++; $display("FAIL reset_iter_counters got %h want 0", {iter_starts, iter_ends, in_flight, ii_max, dut.cyc}); end
        clear_inputs();
        reset = 0;
    endtask

    task automatic test_mod_latency();
        do_reset();
        ap_start = 1; step();
        ap_start = 0;
        vectors++; if (mod_busy !== 1'b1) begin miscompares++; $display("FAIL mod_busy_run got %0d want 1", mod_busy); end
        repeat (8) step();
        ap_done = 1; ap_continue = 1; step();
        ap_done = 0; ap_continue = 0;
        vectors++; if (mod_runs !== 32'd1) begin miscompares++; $display("FAIL mod_runs_1 got %0d want 1", mod_runs); end
        vectors++; if (mod_last_lat !== 32'd10) begin miscompares++; $display("FAIL mod_lat_10 got %0d want 10", mod_last_lat); end
        vectors++; if (mod_busy !== 1'b0) begin miscompares++; $display("FAIL mod_busy_done got %0d want 0", mod_busy); end
    endtask

    task automatic test_mod_hold();
        ap_start = 1; step();
        ap_start = 0; repeat (2) step();
        ap_done = 1; ap_continue = 0; repeat (2) step();
        ap_done = 0;
        vectors++; if (mod_busy !== 1'b1 || mod_runs !== 32'd1)
            begin miscompares++; $display("FAIL mod_hold got busy=%0d runs=%0d want busy=1 runs=1", mod_busy, mod_runs); end
        ap_continue = 1; step();
        ap_continue = 0;
        vectors++; if (mod_runs !== 32'd2) begin miscompares++; $display("FAIL mod_runs_2 got %0d want 2", mod_runs); end
        vectors++; if (mod_last_lat !== 32'd6) begin miscompares++; $display("FAIL mod_hold_lat got %0d want 6", mod_last_lat); end
        ap_start = 1; ap_done = 1; ap_continue = 1; step();
        ap_start = 0; ap_done = 0; ap_continue = 0;
        vectors++; if (mod_runs !== 32'd3 || mod_last_lat !== 32'd1)
            begin miscompares++; $display("FAIL mod_same_cycle got runs=%0d lat=%0d want runs=3 lat=1", mod_runs, mod_last_lat); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        loop_start = 1; step();
        loop_start = 0; iter_start_enable = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin loop_done = 1; loop_continue = 1; end
            step();
        end
        clear_inputs();
        step();
        vectors++; if (loop_runs !== 32'd1) begin miscompares++; $display("FAIL b2b_loop_runs got %0d want 1", loop_runs); end
        vectors++; if (loop_last_trip !== 32'd8) begin miscompares++; $display("FAIL b2b_trip got %0d want 8", loop_last_trip); end
        vectors++; if (loop_last_lat !== 32'd9) begin miscompares++; $display("FAIL b2b_lat got %0d want 9", loop_last_lat); end
        vectors++; if (ii_min !== 32'd1 || ii_max !== 32'd1)
            begin miscompares++; $display("FAIL b2b_ii got min=%0d max=%0d want 1/1", ii_min, ii_max); end
        vectors++; if (iter_starts !== 32'd8) begin miscompares++; $display("FAIL b2b_starts got %0d want 8", iter_starts); end
    endtask

    task automatic test_blocked_start();
        do_reset();
        loop_start = 1; step();
        loop_start = 0; iter_start_enable = 1;
        for (int i = 0; i < 6; i++) begin
            iter_start_block = (i == 2);
            step();
        end
        iter_start_enable = 0; iter_start_block = 0; loop_done = 1; loop_continue = 1; step();
        clear_inputs();
        vectors++; if (iter_starts !== 32'd5 || loop_last_trip !== 32'd5)
            begin miscompares++; $display("FAIL blk_starts got starts=%0d trip=%0d want 5/5", iter_starts, loop_last_trip); end
        vectors++; if (ii_min !== 32'd1 || ii_max !== 32'd2)
            begin miscompares++; $display("FAIL blk_ii got min=%0d max=%0d want 1/2", ii_min, ii_max); end
        vectors++; if (loop_last_lat !== 32'd8) begin miscompares++; $display("FAIL blk_lat got %0d want 8", loop_last_lat); end
    endtask

    task automatic test_pipeline_depth();
        int exp_if[6] = '{1, 2, 2, 2, 1, 0};
        do_reset();
        iter_end_state = 0;
        loop_start = 1; step();
        loop_start = 0;
        for (int c = 0; c < 6; c++) begin
            iter_start_enable = (c <= 3);
            iter_end_enable   = (c >= 2);
            step();
            vectors++; if (in_flight !== 32'(exp_if[c]))
                begin miscompares++; $display("FAIL pipe_in_flight_c%0d got %0d want %0d", c, in_flight, exp_if[c]); end
        end
        clear_inputs();
        vectors++; if (iter_starts !== 32'd4 || iter_ends !== 32'd4)
            begin miscompares++; $display("FAIL pipe_totals got starts=%0d ends=%0d want 4/4", iter_starts, iter_ends); end
    endtask

    task automatic test_quit();
        do_reset();
        loop_start = 1; step();
        loop_start = 0;
        cur_state = 1; iter_end_enable = 1; quit_enable = 1; loop_done = 1; loop_continue = 0;
        quit_at_end = 0; step();
        vectors++; if (loop_runs !== 32'd0) begin miscompares++; $display("FAIL quit_suppressed got runs=%0d want 0", loop_runs); end
        vectors++; if (iter_ends !== 32'd1 || in_flight !== 32'd0)
            begin miscompares++; $display("FAIL quit_underflow got ends=%0d inflight=%0d want 1/0", iter_ends, in_flight); end
        quit_at_end = 1; step();
        clear_inputs();
        vectors++; if (loop_runs !== 32'd1 || loop_last_lat !== 32'd3 || loop_last_trip !== 32'd0)
            begin miscompares++; $display("FAIL quit_exit got runs=%0d lat=%0d trip=%0d want 1/3/0", loop_runs, loop_last_lat, loop_last_trip); end
    endtask

    task automatic test_finish();
        do_reset();
        loop_start = 1; step();
        loop_start = 0; iter_start_enable = 1; repeat (2) step();
        iter_start_enable = 0; finish = 1; step();
        vectors++; if (frozen !== 1'b1) begin miscompares++; $display("FAIL fin_frozen got %0d want 1", frozen); end
        finish = 0; iter_start_enable = 1;
        repeat (4) step();
        loop_done = 1; loop_continue = 1; step();
        clear_inputs();
        vectors++; if (iter_starts !== 32'd2 || in_flight !== 32'd2)
            begin miscompares++; $display("FAIL fin_starts got starts=%0d inflight=%0d want 2/2", iter_starts, in_flight); end
        vectors++; if (dut.cyc !== 32'd3) begin miscompares++; $display("FAIL fin_cyc got %0d want 3", dut.cyc); end
        vectors++; if (loop_runs !== 32'd0 || ii_max !== 32'd1 || frozen !== 1'b1)
            begin miscompares++; $display("FAIL fin_hold got runs=%0d ii_max=%0d frozen=%0d want 0/1/1", loop_runs, ii_max, frozen); end
        do_reset();
        vectors++; if (frozen !== 1'b0 || iter_starts !== 32'd0)
            begin miscompares++; $display("FAIL fin_reset got frozen=%0d starts=%0d want 0/0", frozen, iter_starts); end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_mod_latency();
        test_mod_hold();
        test_back_to_back();
        test_blocked_start();
        test_pipeline_depth();
        test_quit();
        test_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
